pipe_reg_wb: RTL

PIPE_REG_WB -- requirements
Module: pipe_reg_wb

---
 rtl/pipe_reg_wb.sv | 122 ++++++++++++
 1 files changed

// File: rtl/pipe_reg_wb.sv
`default_nettype none
// ============================================================================
// Module   : pipe_reg_wb
// Purpose  : Two-entry write-back pipeline register with skid buffer.
//            The main register drives out_data. The skid register absorbs one
//            entry while the consumer is stalled, so in_ready never depends
//            combinationally on out_ready or waiting. All NCH lanes move
//            together as one entry.
// Ports    : clk        - clock, rising edge
//            rst        - synchronous reset, active low
//            flush      - discard all held entries
//            waiting    - downstream stall, blocks the output transfer
//            in_valid   - upstream entry present
//            in_ready   - block can accept an entry this cycle
//            in_data    - NCH lanes of WIDTH bits each
//            out_valid  - out_data holds a valid entry
//            out_ready  - downstream consumes the entry
//            out_data   - oldest held entry
//            count      - occupancy, 0..2
//            stall_cnt  - saturating count of stalled output cycles
//                         (present only with PIPE_REG_WB_STALL_CNT_EN)
// Macro    : PIPE_REG_WB_STALL_CNT_EN - adds the stall_cnt port and counter
// Revision : 1.0 - initial release
// ============================================================================
module pipe_reg_wb #(
    parameter int WIDTH = 64,
    parameter int NCH   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 waiting,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [1:0]           count
`ifdef PIPE_REG_WB_STALL_CNT_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    // The state encoding equals the occupancy, so count is the state itself.
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    logic [1:0]           r_state;
    logic [NCH*WIDTH-1:0] r_main;
    logic [NCH*WIDTH-1:0] r_skid;
    logic                 w_accept;
    logic                 w_pop;

    // in_ready looks only at flush and local state; the skid slot is what
    // makes it safe to ignore the consumer's handshake here.
    assign in_ready  = !flush && (r_state != TWO);
    assign out_valid = (r_state != EMPTY);
    assign out_data  = r_main;
    assign count     = r_state;

    assign w_accept  = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready && !waiting;

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            // Reset wins over flush; both empty the block and zero the data.
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_main  <= in_data;
                        r_state <= ONE;
                    end
                end
                ONE: begin
                    if (w_accept && w_pop) begin
                        r_main <= in_data;
                    end else if (w_accept) begin
                        r_skid  <= in_data;
                        r_state <= TWO;
                    end else if (w_pop) begin
                        r_state <= EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only the pop can happen.
                    if (w_pop) begin
                        r_main  <= r_skid;
                        r_state <= ONE;
                    end
                end
                default: begin
                    r_state <= EMPTY;
                end
            endcase
        end
    end

`ifdef PIPE_REG_WB_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Counts cycles where a held entry could not leave; flush does not clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (out_valid && (waiting || !out_ready) &&
                     (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire
